// File: rtl/sparce_skip_ctrl.sv
// SparCE fetch-skip redirect sequencer: IDLE -> REQ (held redirect) -> HOLD (holdoff) -> IDLE.
// Optional skip/block statistics counters are built only when SPARCE_SKIP_STATS_EN is defined.
module sparce_skip_ctrl #(
    parameter int HOLDOFF_CYCLES = 2,
    parameter int CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             fetch_valid,
    input  logic             skip_valid,
    input  logic [31:0]      skip_target,
    input  logic             ctrl_flow_enable,
    input  logic             pipe_flush,
    input  logic             redirect_ack,
    output logic             redirect_req,
    output logic [31:0]      redirect_pc,
    output logic             busy,
    output logic [CNT_W-1:0] skip_count,
    output logic [CNT_W-1:0] block_count,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD   = 4'(HOLDOFF_CYCLES);
    localparam bit         HOLD_BYPASS = (HOLDOFF_CYCLES == 0);

    state_t     state;
    logic [3:0] hold_cnt;

    // Handshake: redirect_req rises the cycle after an accept and is held with a stable
    // redirect_pc until redirect_ack is sampled high (or a flush aborts it); ack is ignored
    // whenever redirect_req is low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            hold_cnt     <= 4'd0;
            redirect_req <= 1'b0;
            redirect_pc  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (pipe_flush) begin
                        state    <= HOLD_BYPASS ? IDLE : HOLD;
                        hold_cnt <= HOLD_LOAD;
                    end else if (fetch_valid && skip_valid && ctrl_flow_enable) begin
                        redirect_pc  <= {skip_target[31:2], 2'b00};
                        redirect_req <= 1'b1;
                        state        <= REQ;
                    end
                end
                REQ: begin
                    if (pipe_flush || redirect_ack) begin
                        redirect_req <= 1'b0;
                        state        <= HOLD_BYPASS ? IDLE : HOLD;
                        hold_cnt     <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (pipe_flush) begin
                        hold_cnt <= HOLD_LOAD;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                        if (hold_cnt <= 4'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    redirect_req <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign fsm_state = state;

`ifdef SPARCE_SKIP_STATS_EN
    logic skip_inc;
    logic block_inc;

    // A flushed request is an abort, not a completed redirect.
    assign skip_inc  = (state == REQ) && redirect_ack && !pipe_flush;
    assign block_inc = (state == IDLE) && fetch_valid && skip_valid && !ctrl_flow_enable && !pipe_flush;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            skip_count  <= '0;
            block_count <= '0;
        end else begin
            if (skip_inc && (skip_count != '1)) begin
                skip_count <= skip_count + CNT_W'(1);
            end
            if (block_inc && (block_count != '1)) begin
                block_count <= block_count + CNT_W'(1);
            end
        end
    end
`else
    assign skip_count  = '0;
    assign block_count = '0;
`endif

endmodule

// File: tb/tb_sparce_skip_ctrl.sv
// Directed bench for sparce_skip_ctrl: a default instance (H=2, CNT_W=32) and a
// bypass/saturation instance (H=0, CNT_W=4).
module tb_sparce_skip_ctrl;

`ifdef SPARCE_SKIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK;
    logic        RST;

    logic        fetch_valid, skip_valid, ctrl_flow_enable, pipe_flush, redirect_ack;
    logic [31:0] skip_target;
    logic        redirect_req, busy;
    logic [31:0] redirect_pc, skip_count, block_count;
    logic [1:0]  fsm_state;

    logic        b_fetch_valid, b_skip_valid, b_ctrl_flow_enable, b_pipe_flush, b_redirect_ack;
    logic [31:0] b_skip_target;
    logic        b_redirect_req, b_busy;
    logic [31:0] b_redirect_pc;
    logic [3:0]  b_skip_count, b_block_count;
    logic [1:0]  b_fsm_state;

    int vectors    = 0;
    int miscompares = 0;
    int exp_skip   = 0;
    int exp_block  = 0;

    sparce_skip_ctrl #(.HOLDOFF_CYCLES(2), .CNT_W(32)) u_dut (
        .CLK(CLK), .RST(RST),
        .fetch_valid(fetch_valid), .skip_valid(skip_valid), .skip_target(skip_target),
        .ctrl_flow_enable(ctrl_flow_enable), .pipe_flush(pipe_flush), .redirect_ack(redirect_ack),
        .redirect_req(redirect_req), .redirect_pc(redirect_pc), .busy(busy),
        .skip_count(skip_count), .block_count(block_count), .fsm_state(fsm_state)
    );

    sparce_skip_ctrl #(.HOLDOFF_CYCLES(0), .CNT_W(4)) u_dut_b (
        .CLK(CLK), .RST(RST),
        .fetch_valid(b_fetch_valid), .skip_valid(b_skip_valid), .skip_target(b_skip_target),
        .ctrl_flow_enable(b_ctrl_flow_enable), .pipe_flush(b_pipe_flush), .redirect_ack(b_redirect_ack),
        .redirect_req(b_redirect_req), .redirect_pc(b_redirect_pc), .busy(b_busy),
        .skip_count(b_skip_count), .block_count(b_block_count), .fsm_state(b_fsm_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_valid = 0; skip_valid = 0; ctrl_flow_enable = 0; pipe_flush = 0; redirect_ack = 0;
        skip_target = 32'hDEAD_BEEF;
        b_fetch_valid = 0; b_skip_valid = 0; b_ctrl_flow_enable = 0; b_pipe_flush = 0; b_redirect_ack = 0;
        b_skip_target = 32'h0;
    endtask

    task automatic drive_accept(input logic [31:0] tgt);
        fetch_valid = 1; skip_valid = 1; ctrl_flow_enable = 1; skip_target = tgt;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        tick();
        tick();
        vectors++; if (redirect_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", redirect_req); end
        vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", redirect_pc); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (fsm_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        vectors++; if (skip_count !== 32'h0 || block_count !== 32'h0) begin miscompares++; $display("FAIL reset_counts: got %h/%h want 0/0", skip_count, block_count); end
        vectors++; if (b_redirect_req !== 1'b0 || b_busy !== 1'b0 || b_skip_count !== 4'h0) begin miscompares++; $display("FAIL reset_b: got req %b busy %b cnt %h want 0", b_redirect_req, b_busy, b_skip_count); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_accept_ack();
        drive_accept(32'h0000_2003);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (redirect_req !== 1'b1) begin miscompares++; $display("FAIL accept_req[%0d]: got %b want 1", i, redirect_req); end
            vectors++; if (redirect_pc !== 32'h0000_2000) begin miscompares++; $display("FAIL accept_pc[%0d]: got %h want 00002000", i, redirect_pc); end
            if (i < 2) tick();
        end
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        exp_skip++;
        vectors++; if (redirect_req !== 1'b0) begin miscompares++; $display("FAIL ack_req_drop: got %b want 0", redirect_req); end
        vectors++; if (skip_count !== (STATS ? 32'(exp_skip) : 32'h0)) begin miscompares++; $display("FAIL ack_skip_count: got %0d want %0d", skip_count, STATS ? exp_skip : 0); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold1_busy: got %b want 1", busy); end
        tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold2_busy: got %b want 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_end_busy: got %b want 0", busy); end
        vectors++; if (redirect_pc !== 32'h0000_2000) begin miscompares++; $display("FAIL pc_kept: got %h want 00002000", redirect_pc); end
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        vectors++; if (redirect_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL stray_ack: got req %b busy %b want 0 0", redirect_req, busy); end
        vectors++; if (skip_count !== (STATS ? 32'(exp_skip) : 32'h0)) begin miscompares++; $display("FAIL stray_ack_count: got %0d want %0d", skip_count, STATS ? exp_skip : 0); end
    endtask

    task automatic test_block();
        fetch_valid = 1; skip_valid = 1; ctrl_flow_enable = 0; skip_target = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_block++;
            vectors++; if (redirect_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL block_req[%0d]: got req %b busy %b want 0 0", i, redirect_req, busy); end
            vectors++; if (block_count !== (STATS ? 32'(exp_block) : 32'h0)) begin miscompares++; $display("FAIL block_count[%0d]: got %0d want %0d", i, block_count, STATS ? exp_block : 0); end
        end
        fetch_valid = 0; ctrl_flow_enable = 1;
        tick();
        tick();
        ctrl_flow_enable = 0;
        tick();
        idle_inputs();
        vectors++; if (redirect_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL no_fetch_req: got req %b busy %b want 0 0", redirect_req, busy); end
        vectors++; if (block_count !== (STATS ? 32'(exp_block) : 32'h0)) begin miscompares++; $display("FAIL no_fetch_block: got %0d want %0d", block_count, STATS ? exp_block : 0); end
    endtask

    task automatic test_flush_ack();
        drive_accept(32'h0000_4007);
        tick();
        idle_inputs();
        vectors++; if (redirect_req !== 1'b1 || redirect_pc !== 32'h0000_4004) begin miscompares++; $display("FAIL fa_accept: got req %b pc %h want 1 00004004", redirect_req, redirect_pc); end
        pipe_flush = 1; redirect_ack = 1;
        tick();
        idle_inputs();
        vectors++; if (redirect_req !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL fa_abort: got req %b busy %b want 0 1", redirect_req, busy); end
        vectors++; if (skip_count !== (STATS ? 32'(exp_skip) : 32'h0)) begin miscompares++; $display("FAIL fa_count: got %0d want %0d", skip_count, STATS ? exp_skip : 0); end
        tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fa_hold2: got %b want 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fa_idle: got %b want 0", busy); end
    endtask

    task automatic test_hold_flush();
        drive_accept(32'h0000_5000);
        tick();
        idle_inputs();
        redirect_ack = 1;
        tick();
        idle_inputs();
        exp_skip++;
        drive_accept(32'h0000_6000);
        tick();
        vectors++; if (redirect_req !== 1'b0 || busy !== 1'b1 || redirect_pc !== 32'h0000_5000) begin miscompares++; $display("FAIL hold_accept_ignored: got req %b busy %b pc %h want 0 1 00005000", redirect_req, busy, redirect_pc); end
        pipe_flush = 1;
        tick();
        idle_inputs();
        vectors++; if (busy !== 1'b1 || redirect_req !== 1'b0) begin miscompares++; $display("FAIL hflush_1: got busy %b req %b want 1 0", busy, redirect_req); end
        tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hflush_2: got %b want 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0 || redirect_pc !== 32'h0000_5000) begin miscompares++; $display("FAIL hflush_idle: got busy %b pc %h want 0 00005000", busy, redirect_pc); end
        vectors++; if (skip_count !== (STATS ? 32'(exp_skip) : 32'h0)) begin miscompares++; $display("FAIL hflush_count: got %0d want %0d", skip_count, STATS ? exp_skip : 0); end
    endtask

    task automatic test_flush_idle();
        drive_accept(32'h0000_7000);
        pipe_flush = 1;
        tick();
        idle_inputs();
        vectors++; if (redirect_req !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL iflush_1: got req %b busy %b want 0 1", redirect_req, busy); end
        tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL iflush_2: got %b want 1", busy); end
        tick();
        vectors++; if (busy !== 1'b0 || redirect_pc !== 32'h0000_5000) begin miscompares++; $display("FAIL iflush_idle: got busy %b pc %h want 0 00005000", busy, redirect_pc); end
    endtask

    task automatic test_reset_mid_req();
        drive_accept(32'h0000_1040);
        tick();
        idle_inputs();
        vectors++; if (redirect_req !== 1'b1 || redirect_pc !== 32'h0000_1040) begin miscompares++; $display("FAIL mid_setup: got req %b pc %h want 1 00001040", redirect_req, redirect_pc); end
        #2;
        RST = 1'b1;
        #1;
        vectors++; if (redirect_req !== 1'b0 || redirect_pc !== 32'h0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got req %b pc %h busy %b want 0 0 0", redirect_req, redirect_pc, busy); end
        vectors++; if (skip_count !== 32'h0 || block_count !== 32'h0 || fsm_state !== 2'd0) begin miscompares++; $display("FAIL mid_reset_cnt: got %h/%h st %0d want 0/0/0", skip_count, block_count, fsm_state); end
        tick();
        RST = 1'b0;
        exp_skip = 0;
        exp_block = 0;
        redirect_ack = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (redirect_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL post_reset[%0d]: got req %b busy %b want 0 0", i, redirect_req, busy); end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] tgt;
        logic [3:0]  exp_cnt;
        b_fetch_valid = 1; b_skip_valid = 1; b_ctrl_flow_enable = 1; b_redirect_ack = 1;
        tgt = 32'h0;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                tgt = 32'h0000_8000 + 32'(i * 16);
                b_skip_target = tgt | 32'h3;
            end
            tick();
            if (i % 2 == 0) begin
                vectors++; if (b_redirect_req !== 1'b1 || b_redirect_pc !== tgt || b_busy !== 1'b1) begin miscompares++; $display("FAIL b2b_req[%0d]: got req %b pc %h busy %b want 1 %h 1", i, b_redirect_req, b_redirect_pc, b_busy, tgt); end
            end else begin
                exp_cnt = STATS ? (((i + 1) / 2 > 15) ? 4'hF : 4'((i + 1) / 2)) : 4'h0;
                vectors++; if (b_redirect_req !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle[%0d]: got req %b busy %b want 0 0", i, b_redirect_req, b_busy); end
                vectors++; if (b_skip_count !== exp_cnt) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, b_skip_count, exp_cnt); end
            end
        end
        b_pipe_flush = 1;
        tick();
        vectors++; if (b_redirect_req !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL b_flush_idle: got req %b busy %b want 0 0", b_redirect_req, b_busy); end
        b_pipe_flush = 0;
        tick();
        b_pipe_flush = 1;
        tick();
        idle_inputs();
        vectors++; if (b_redirect_req !== 1'b0 || b_busy !== 1'b0) begin miscompares++; $display("FAIL b_flush_req: got req %b busy %b want 0 0", b_redirect_req, b_busy); end
        vectors++; if (b_skip_count !== (STATS ? 4'hF : 4'h0)) begin miscompares++; $display("FAIL b_sat: got %0d want %0d", b_skip_count, STATS ? 15 : 0); end
    endtask

    initial begin
        test_reset();
        test_accept_ack();
        test_block();
        test_flush_ack();
        test_hold_flush();
        test_flush_idle();
        test_reset_mid_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
